// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one row at a time,
// debounces presses and releases, and reports each accepted key once.
//
// Ports:
//   clk       - system clock, all logic on the rising edge
//   reset     - synchronous, active-high reset
//   cols      - column lines (active-low, pulled up, asynchronous to clk)
//   rows      - row drive (active-low, exactly one bit low)
//   key       - code of the last accepted key, 4*row + col
//   key_valid - one-cycle pulse when a new key is accepted
//   value     - four hex digits of entry, newest digit in [3:0]
module keypad_scanner #(
  parameter logic [19:0] SCAN_DIV = 20'd50000,
  parameter logic [3:0]  DEBOUNCE = 4'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cols,
  output logic [3:0]  rows,
  output logic [3:0]  key,
  output logic        key_valid,
  output logic [15:0] value
);

  localparam int unsigned DivW = 20;
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE_PRESS,
    PRESSED,
    DEBOUNCE_RELEASE
  } state_e;

  logic [3:0]      sync1_q, cs_q;
  logic [DivW-1:0] div_q, div_d;
  state_e          state_q, state_d;
  logic [3:0]      rows_q, rows_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [3:0]      code_q, code_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      key_q, key_d;
  logic            key_valid_q, key_valid_d;
  logic [15:0]     value_q, value_d;

  logic            sample_c;
  logic            col_ok_c;
  logic [1:0]      col_idx_c;
  logic [3:0]      new_code_c;
  logic            accept_c;
  logic            advance_c;

  // Two-flop synchroniser for the asynchronous column lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 4'b1111;
      cs_q    <= 4'b1111;
    end else begin
      sync1_q <= cols;
      cs_q    <= sync1_q;
    end
  end

  // Scan divider: one sample per SCAN_DIV cycles.
  assign sample_c = (div_q == SCAN_DIV - 20'd1);
  assign div_d    = sample_c ? '0 : div_q + DivW'(1);

  // A key is only recognised when exactly one column is pulled low.
  always_comb begin
    col_ok_c  = 1'b0;
    col_idx_c = 2'd0;
    case (cs_q)
      4'b1110: begin col_ok_c = 1'b1; col_idx_c = 2'd0; end
      4'b1101: begin col_ok_c = 1'b1; col_idx_c = 2'd1; end
      4'b1011: begin col_ok_c = 1'b1; col_idx_c = 2'd2; end
      4'b0111: begin col_ok_c = 1'b1; col_idx_c = 2'd3; end
      default: begin col_ok_c = 1'b0; col_idx_c = 2'd0; end
    endcase
  end

  assign new_code_c = {row_idx_q, col_idx_c};

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    row_idx_d   = row_idx_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    value_d     = value_q;
    accept_c    = 1'b0;
    advance_c   = 1'b0;

    unique case (state_q)
      SCAN: begin
        if (sample_c) begin
          if (col_ok_c) begin
            code_d = new_code_c;
            cnt_d  = CntW'(1);
            if (DEBOUNCE <= 4'd1) accept_c = 1'b1;
            else                  state_d  = DEBOUNCE_PRESS;
          end else begin
            advance_c = 1'b1;
          end
        end
      end

      DEBOUNCE_PRESS: begin
        if (sample_c) begin
          if (col_ok_c && (new_code_c == code_q)) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q + CntW'(1) >= DEBOUNCE) accept_c = 1'b1;
          end else begin
            // Bounce: rescan the same row on the next sample.
            state_d = SCAN;
            cnt_d   = '0;
          end
        end
      end

      PRESSED: begin
        if (sample_c && !col_ok_c) begin
          if (DEBOUNCE <= 4'd1) begin
            state_d   = SCAN;
            cnt_d     = '0;
            advance_c = 1'b1;
          end else begin
            state_d = DEBOUNCE_RELEASE;
            cnt_d   = CntW'(1);
          end
        end
      end

      DEBOUNCE_RELEASE: begin
        if (sample_c) begin
          if (!col_ok_c) begin
            if (cnt_q + CntW'(1) >= DEBOUNCE) begin
              state_d   = SCAN;
              cnt_d     = '0;
              advance_c = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end else begin
            // Key still (or again) down: no new key_valid.
            state_d = PRESSED;
            cnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase

    if (accept_c) begin
      state_d     = PRESSED;
      cnt_d       = '0;
      key_d       = new_code_c;
      key_valid_d = 1'b1;
      value_d     = {value_q[11:0], new_code_c};
    end

    if (advance_c) begin
      rows_d    = {rows_q[2:0], rows_q[3]};
      row_idx_d = row_idx_q + 2'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      state_q     <= SCAN;
      rows_q      <= 4'b1110;
      row_idx_q   <= 2'd0;
      code_q      <= 4'd0;
      cnt_q       <= '0;
      key_q       <= 4'd0;
      key_valid_q <= 1'b0;
      value_q     <= 16'h0000;
    end else begin
      div_q       <= div_d;
      state_q     <= state_d;
      rows_q      <= rows_d;
      row_idx_q   <= row_idx_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      value_q     <= value_d;
    end
  end

  assign rows      = rows_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign value     = value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3. A keypad model
// closes switches from a 16-bit mask (bit 4*row+col); expected key/value
// pairs are queued when a press is driven and compared on each key_valid.
module tb_keypad_scanner;

  localparam logic [19:0] SD = 20'd4;
  localparam logic [3:0]  DB = 4'd3;
  localparam int unsigned SD_CYC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [3:0]  key;
  logic        key_valid;
  logic [15:0] value;

  logic [15:0] mask = 16'h0000;

  typedef struct packed {
    logic [3:0]  key;
    logic [15:0] value;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] vm = 16'h0000;
  int          n_checks = 0;
  int          n_errors = 0;
  int          rows_bad = 0;
  bit          started = 1'b0;
  logic [3:0]  seen;
  logic [3:0]  rot [4];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .rows      (rows),
    .key       (key),
    .key_valid (key_valid),
    .value     (value)
  );

  always #5 clk = ~clk;

  // Matrix model: a closed switch pulls its column low while its row is driven.
  always_comb begin
    cols = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[4*r+c] && !rows[r]) cols[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_key(input logic [3:0] k);
    vm = {vm[11:0], k};
    sb.push_back({k, vm});
  endtask

  task automatic wait_samples(input int n);
    repeat (n * SD_CYC) @(posedge clk);
  endtask

  // One-cycle reset; leaves the caller at the negedge after the reset edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    started = 1'b1;
    check({tag, "_rows"}, 32'(rows), 32'h0000_000E);
    check({tag, "_key"}, 32'(key), 32'h0);
    check({tag, "_kv"}, 32'(key_valid), 32'h0);
    check({tag, "_value"}, 32'(value), 32'h0);
    reset = 1'b0;
    vm = 16'h0000;
  endtask

  // Scoreboard monitor: every key_valid must match a queued expectation.
  always @(negedge clk) begin
    if (started) begin
      if ($countones(~rows) != 1) rows_bad++;
      if (key_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_key_valid", 32'(key_valid), 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_key", 32'(key), 32'(mon_e.key));
          check("pulse_value", 32'(value), 32'(mon_e.value));
        end
      end
    end
  end

  initial begin
    rot[0] = 4'b1101;
    rot[1] = 4'b1011;
    rot[2] = 4'b0111;
    rot[3] = 4'b1110;

    // Idle rotation after reset.
    do_reset("rst0");
    for (int i = 0; i < 4; i++) begin
      repeat (SD_CYC - 1) @(posedge clk);
      @(negedge clk);
      check($sformatf("idle_hold%0d", i), 32'(rows), 32'(i == 0 ? 4'b1110 : rot[i-1]));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("idle_rot%0d", i), 32'(rows), 32'(rot[i]));
    end

    // Press row 2 / col 1, hold long: exactly one pulse.
    mask = 16'h0001 << 9;
    expect_key(4'h9);
    wait_samples(110);
    check("press_pending", 32'(sb.size()), 32'h0);
    check("press_key", 32'(key), 32'h9);
    check("press_value", 32'(value), 32'h0009);
    mask = 16'h0000;
    wait_samples(8);

    // Sequential entry of keys 1..5 with full releases.
    for (int k = 1; k <= 5; k++) begin
      mask = 16'h0001 << k;
      expect_key(4'(k));
      wait_samples(12);
      mask = 16'h0000;
      wait_samples(8);
    end
    check("entry_pending", 32'(sb.size()), 32'h0);
    check("entry_value", 32'(value), 32'h0000_2345);
    check("entry_key", 32'(key), 32'h5);

    // Ghosting: two columns on row 1 must not register, scan keeps rotating.
    mask = (16'h0001 << 4) | (16'h0001 << 6);
    seen = 4'h0;
    for (int i = 0; i < 8; i++) begin
      wait_samples(1);
      @(negedge clk);
      seen = seen | ~rows;
    end
    check("ghost_rows_seen", 32'(seen), 32'hF);
    check("ghost_key", 32'(key), 32'h5);
    check("ghost_pending", 32'(sb.size()), 32'h0);
    mask = 16'h0000;
    wait_samples(4);

    // Bounce: closure toggles on alternate samples, then held stable.
    check("bounce_pre_pending", 32'(sb.size()), 32'h0);
    do_reset("rst1");
    mask = 16'h0001 << 9;
    expect_key(4'h9);
    for (int i = 0; i < 20; i++) begin
      repeat (SD_CYC) @(posedge clk);
      #1;
      mask = (i % 2 == 1) ? (16'h0001 << 9) : 16'h0000;
    end
    repeat (2 * SD_CYC) @(posedge clk);
    @(negedge clk);
    check("bounce_early", 32'(key_valid), 32'h0);
    repeat (SD_CYC) @(posedge clk);
    @(negedge clk);
    check("bounce_pulse", 32'(key_valid), 32'h1);
    check("bounce_value", 32'(value), 32'h0009);
    mask = 16'h0000;
    wait_samples(8);
    check("bounce_pending", 32'(sb.size()), 32'h0);

    // Reset while in DEBOUNCE_PRESS: press discarded, re-debounced afterwards.
    do_reset("rst2");
    mask = 16'h0001 << 9;
    repeat (3 * SD_CYC) @(posedge clk);
    do_reset("rst_mid");
    expect_key(4'h9);
    repeat (4 * SD_CYC) @(posedge clk);
    @(negedge clk);
    check("midrst_early", 32'(key_valid), 32'h0);
    repeat (SD_CYC) @(posedge clk);
    @(negedge clk);
    check("midrst_pulse", 32'(key_valid), 32'h1);
    mask = 16'h0000;
    wait_samples(8);

    check("final_pending", 32'(sb.size()), 32'h0);
    check("rows_one_low", 32'(rows_bad), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 20'd50000: clock cycles each row is driven before its columns are sampled; legal range 4..2^20-1.
REQ-002 Parameter DEBOUNCE, default 4'd4: consecutive identical samples required to accept a press or a release; legal range 1..15.
REQ-003 Port clk  input  1: single system clock; all logic is on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port cols  input  4: keypad column lines, active-low, externally pulled up; asynchronous to clk.
REQ-006 Port rows  output  4: keypad row drive, active-low, exactly one bit low at any time.
REQ-007 Port key  output  4: code of the last accepted key = 4*row_index + col_index.
REQ-008 Port key_valid  output  1: one-cycle pulse marking a newly accepted key.
REQ-009 Port value  output  16: four-digit hex entry register, suitable for driving the four-digit display.

Function
REQ-010 cols SHALL pass through a 2-flop synchroniser; all decisions use the synchronised value (cs).
REQ-011 A divider SHALL count 0..SCAN_DIV-1; a sample occurs in the cycle where it equals SCAN_DIV-1, then it wraps to 0.
REQ-012 A column code SHALL be valid only when exactly one bit of cs is 0; zero or multiple low bits count as "no key".
REQ-013 The FSM SHALL have the states SCAN, DEBOUNCE_PRESS, PRESSED and DEBOUNCE_RELEASE.
REQ-014 SCAN: on a sample with no key, rows SHALL rotate to the next row (0->1->2->3->0, row i drives bit i low) in the following cycle; on a sample with a valid code, the FSM latches the code, sets the match count to 1, holds the row and goes to DEBOUNCE_PRESS.
REQ-015 DEBOUNCE_PRESS: each sample matching the latched code increments the match count; any other sample returns the FSM to SCAN (the row does not advance on that sample).
REQ-016 When the match count reaches DEBOUNCE, the FSM SHALL enter PRESSED, load key, assert key_valid for exactly that one cycle, and shift value left 4 with key in [3:0]; with DEBOUNCE=1 this happens on the first valid sample.
REQ-017 PRESSED: the row is held; the first sample with no key enters DEBOUNCE_RELEASE with the release count set to 1.
REQ-018 DEBOUNCE_RELEASE: no-key samples increment the release count; any key sample returns to PRESSED without a new key_valid; reaching DEBOUNCE returns to SCAN and advances the row.
REQ-019 A key held indefinitely SHALL produce exactly one key_valid (no auto-repeat).
REQ-020 rows SHALL remain constant in every cycle except the cycle after a SCAN sample or a release completion.
REQ-021 key and value SHALL change only in the key_valid cycle; value discards its old [15:12] digit on each shift.
REQ-022 If reset is asserted in any state, the next cycle SHALL show reset values, with no key_valid pulse.

Reset
REQ-023 On reset: rows=4'b1110, key=0, key_valid=0, value=16'h0000, divider=0, counts=0, synchroniser flops=4'b1111, state=SCAN.
REQ-024 A press in progress at reset SHALL be discarded; the key must be re-debounced after reset to be accepted.

Verification (SCAN_DIV=4, DEBOUNCE=3)
REQ-025 Idle: cols=4'b1111 after reset -> rows cycles 1110,1101,1011,0111,1110 changing every 4 clocks; key_valid never asserts.
REQ-026 Press: model row 2 / col 1 closed (cols[1] low while rows[2] low) -> one key_valid with key=4'h9, value=16'h0009; holding for 100 samples produces no further pulse.
REQ-027 Bounce: toggle the closure on alternate samples for 20 samples, then hold for 3 samples -> exactly one key_valid, issued at the third stable sample.
REQ-028 Entry: press keys 1,2,3,4,5 sequentially with full releases -> value ends at 16'h2345, with 5 pulses.
REQ-029 Ghosting: close col 0 and col 2 together on row 1 -> no key_valid and the scan continues rotating.
REQ-030 Reset mid-press: assert reset for 1 cycle during DEBOUNCE_PRESS -> outputs return to reset values, no pulse; the key is accepted 3 samples after it is rescanned.
